// File: rtl/aes_decipher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// aes_decipher : iterative AES-128/256 inverse cipher, one round per cycle,
//                round keys fetched combinationally from an external key store
// Revision     : 1.0
// ============================================================================
module aes_decipher #(
    parameter int AES128_ROUNDS = 10,
    parameter int AES256_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [3:0] c_nr128 = 4'(AES128_ROUNDS);
    localparam logic [3:0] c_nr256 = 4'(AES256_ROUNDS);

    // FIPS-197 inverse S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   blk_q, blk_d;
    logic           ready_q, ready_d;

    logic [127:0]   w_shifted;
    logic [127:0]   w_subbed;
    logic [127:0]   w_added;
    logic [127:0]   w_mixed;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_inv_sbox[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (column c, row r) lives at bits 127-8*(4c+r) downwards
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    assign w_shifted = inv_shift_rows(blk_q);
    assign w_subbed  = inv_sub_bytes(w_shifted);
    assign w_added   = w_subbed ^ round_key;
    assign w_mixed   = inv_mix_columns(w_added);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (next) begin
                    cnt_d   = keylen ? c_nr256 : c_nr128;
                    ready_d = 1'b0;
                    state_d = INIT;
                end
            end
            INIT: begin
                blk_d   = block ^ round_key;
                cnt_d   = cnt_q - 4'd1;
                state_d = MAIN;
            end
            MAIN: begin
                if (cnt_q != 4'd0) begin
                    blk_d = w_mixed;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Final round skips InvMixColumns and never decrements
                    blk_d   = w_added;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            blk_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ready_q <= ready_d;
        end
    end

    assign round     = cnt_q;
    assign new_block = blk_q;
    assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_decipher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_aes_decipher : directed and loopback checks of aes_decipher against
//                   FIPS-197 vectors and an independent forward-cipher model
// Revision        : 1.0
// ============================================================================
module tb_aes_decipher;

    localparam logic [127:0] c_ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] c_pt    = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
    logic         ks_sel;

    logic [7:0]   sb [0:255];
    logic [127:0] rk_tab [0:1][0:14];

    int checks = 0;
    int errors = 0;

    aes_decipher #(
        .AES128_ROUNDS(10),
        .AES256_ROUNDS(14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Key store follows the key of the operation in flight, not the keylen pin
    assign round_key = (round <= 4'd14) ? rk_tab[ks_sel][round] : '0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic build_tables();
        logic [7:0]  inv;
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk_tab[0][r] = (r <= 10) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
        for (int i = 0; i < 8; i++) w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk_tab[1][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Forward cipher used to produce ciphertexts for the loopback checks
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int m);
        logic [127:0] s, o;
        logic [7:0]   a0, a1, a2, a3;
        int           nr;
        nr = (m != 0) ? 14 : 10;
        s  = pt ^ rk_tab[m][0];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) s[127 - 8 * i -: 8] = sb[s[127 - 8 * i -: 8]];
            o = '0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            s = o;
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32 * c -: 8];
                    a1 = s[119 - 32 * c -: 8];
                    a2 = s[111 - 32 * c -: 8];
                    a3 = s[103 - 32 * c -: 8];
                    o[127 - 32 * c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
                s = o;
            end
            s = s ^ rk_tab[m][rd];
        end
        return s;
    endfunction

    task automatic start_op(input logic kl, input logic [127:0] ct);
        block  = ct;
        keylen = kl;
        ks_sel = kl;
        next   = 1'b1;
        @(posedge clk); #1;
        next   = 1'b0;
    endtask

    task automatic wait_ready(input int max_c, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < max_c) begin
            @(posedge clk); #1;
            cyc++;
            if (ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ready !== 1'b0 || new_block !== '0 || round !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b round=%0d new_block=%h, required 0/0/0", ready, round, new_block);
        end
    endtask

    task automatic test_aes(input logic kl, input logic [127:0] ct, input int lat);
        int cyc;
        bit ok;
        start_op(kl, ct);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_ready(kl=%0d): ready=%b, required 0", kl, ready);
        end
        wait_ready(40, cyc, ok);
        checks++;
        if (!ok || cyc != lat) begin
            errors++;
            $display("FAIL latency(kl=%0d): ok=%0d cycles=%0d, required %0d", kl, ok, cyc, lat);
        end
        checks++;
        if (new_block !== c_pt) begin
            errors++;
            $display("FAIL plaintext(kl=%0d): got %h, required %h", kl, new_block, c_pt);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b1 || new_block !== c_pt || round !== 4'd0) begin
                errors++;
                $display("FAIL hold(kl=%0d): ready=%b round=%0d new_block=%h", kl, ready, round, new_block);
            end
        end
    endtask

    task automatic test_round_seq();
        logic [3:0] exp_r;
        start_op(1'b0, c_ct128);
        for (int k = 0; k <= 11; k++) begin
            exp_r = (k <= 10) ? 4'(10 - k) : 4'd0;
            checks++;
            if (round !== exp_r) begin
                errors++;
                $display("FAIL round_seq[%0d]: round=%0d, required %0d", k, round, exp_r);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b1 || new_block !== c_pt) begin
            errors++;
            $display("FAIL round_seq_result: ready=%b new_block=%h, required 1/%h", ready, new_block, c_pt);
        end
    endtask

    task automatic test_ignore_next();
        int  completions;
        int  done_at;
        logic prev;
        completions = 0;
        done_at     = -1;
        start_op(1'b0, c_ct128);
        prev = ready;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 10) begin
                next   = 1'(k % 2);
                keylen = ~keylen;
            end else begin
                next = 1'b0;
            end
            @(posedge clk); #1;
            if (ready === 1'b1 && prev !== 1'b1) begin
                completions++;
                if (done_at < 0) done_at = k;
            end
            prev = ready;
        end
        checks++;
        if (completions != 1 || done_at != 11) begin
            errors++;
            $display("FAIL ignore_next_completions: count=%0d at=%0d, required 1 at 11", completions, done_at);
        end
        checks++;
        if (new_block !== c_pt || ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_next_result: ready=%b new_block=%h, required 1/%h", ready, new_block, c_pt);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt2, ct2;
        int cyc;
        bit ok;
        pt2    = {$urandom(), $urandom(), $urandom(), $urandom()};
        ct2    = encrypt(pt2, 0);
        block  = c_ct128;
        keylen = 1'b0;
        ks_sel = 1'b0;
        next   = 1'b1;
        @(posedge clk); #1;
        wait_ready(40, cyc, ok);
        checks++;
        if (!ok || cyc != 11 || new_block !== c_pt) begin
            errors++;
            $display("FAIL b2b_first: ok=%0d cycles=%0d new_block=%h, required 11/%h", ok, cyc, new_block, c_pt);
        end
        block = ct2;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || round !== 4'd10) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b round=%0d, required 0/10", ready, round);
        end
        wait_ready(40, cyc, ok);
        next = 1'b0;
        checks++;
        if (!ok || cyc != 11 || new_block !== pt2) begin
            errors++;
            $display("FAIL b2b_second: ok=%0d cycles=%0d new_block=%h, required 11/%h", ok, cyc, new_block, pt2);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || new_block !== pt2) begin
            errors++;
            $display("FAIL b2b_stop: ready=%b new_block=%h, required 1/%h", ready, new_block, pt2);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int cyc;
        bit ok;
        found = 1'b0;
        start_op(1'b0, c_ct128);
        for (int k = 0; k < 20 && !found; k++) begin
            if (round === 4'd5) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_reach: round=%0d, required 5 within 20 cycles", round);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (new_block !== '0 || ready !== 1'b0 || round !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_async: ready=%b round=%0d new_block=%h, required 0/0/0", ready, round, new_block);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin
            checks++;
            if (ready !== 1'b0 || round !== 4'd0) begin
                errors++;
                $display("FAIL reset_mid_idle: ready=%b round=%0d, required 0/0", ready, round);
            end
            @(posedge clk); #1;
        end
        start_op(1'b0, c_ct128);
        wait_ready(40, cyc, ok);
        checks++;
        if (!ok || cyc != 11 || new_block !== c_pt) begin
            errors++;
            $display("FAIL reset_mid_restart: ok=%0d cycles=%0d new_block=%h, required 11/%h", ok, cyc, new_block, c_pt);
        end
    endtask

    task automatic test_loopback();
        logic [127:0] pt, ct;
        int cyc;
        bit ok;
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 6; n++) begin
                pt = {$urandom(), $urandom(), $urandom(), $urandom()};
                ct = encrypt(pt, m);
                start_op(1'(m), ct);
                wait_ready(40, cyc, ok);
                checks++;
                if (!ok || new_block !== pt) begin
                    errors++;
                    $display("FAIL loopback(kl=%0d,#%0d): ok=%0d got %h, required %h", m, n, ok, new_block, pt);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        next   = 1'b0;
        keylen = 1'b0;
        ks_sel = 1'b0;
        block  = '0;
        build_tables();
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_aes(1'b0, c_ct128, 11);
        test_aes(1'b1, c_ct256, 15);
        test_round_seq();
        test_ignore_next();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
